// File: rtl/alu_op_sequencer.sv
// Issue controller for the 64-bit ALU result mux; runs non-zero shifts itself, one bit per cycle.
// Latency: 2 cycles accept-to-result, or 1+shamt for shifts. A result held in DONE blocks new requests.
module alu_op_sequencer #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] alu_result_in,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int SW = $clog2(XLEN);

    localparam logic [3:0] SEL_ADD  = 4'd0;
    localparam logic [3:0] SEL_SUB  = 4'd1;
    localparam logic [3:0] SEL_AND  = 4'd2;
    localparam logic [3:0] SEL_OR   = 4'd3;
    localparam logic [3:0] SEL_XOR  = 4'd4;
    localparam logic [3:0] SEL_SLL  = 4'd5;
    localparam logic [3:0] SEL_SRL  = 4'd6;
    localparam logic [3:0] SEL_SRA  = 4'd7;
    localparam logic [3:0] SEL_SLT  = 4'd8;
    localparam logic [3:0] SEL_SLTU = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    logic [XLEN-1:0] shift_reg;
    logic [XLEN-1:0] shift_next;
    logic [SW-1:0]   cnt;
    logic [SW-1:0]   req_shamt;
    logic [3:0]      req_code;
    logic            req_is_shift;

    // Only the shift amount of op_b is used by the sequencer itself.
    logic unused_opb;
    assign unused_opb = ^op_b[XLEN-1:SW];

    always_comb begin
        req_code = SEL_ADD;
        case (funct3)
            3'b000:  req_code = funct7_5 ? SEL_SUB : SEL_ADD;
            3'b001:  req_code = SEL_SLL;
            3'b010:  req_code = SEL_SLT;
            3'b011:  req_code = SEL_SLTU;
            3'b100:  req_code = SEL_XOR;
            3'b101:  req_code = funct7_5 ? SEL_SRA : SEL_SRL;
            3'b110:  req_code = SEL_OR;
            default: req_code = SEL_AND;
        endcase
    end

    assign req_shamt    = op_b[SW-1:0];
    assign req_is_shift = (req_code == SEL_SLL || req_code == SEL_SRL || req_code == SEL_SRA)
                          && (req_shamt != '0);

    // alu_sel holds the latched shift code while in SHIFT, so it picks the direction.
    always_comb begin
        shift_next = shift_reg;
        case (alu_sel)
            SEL_SLL: shift_next = {shift_reg[XLEN-2:0], 1'b0};
            SEL_SRL: shift_next = {1'b0, shift_reg[XLEN-1:1]};
            default: shift_next = {shift_reg[XLEN-1], shift_reg[XLEN-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            alu_sel   <= SEL_ADD;
            result    <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            shift_reg <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        alu_sel   <= req_code;
                        shift_reg <= op_a;
                        cnt       <= req_shamt;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= req_is_shift ? SHIFT : EXEC;
                    end
                end
                EXEC: begin
                    result    <= alu_result_in;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                SHIFT: begin
                    shift_reg <= shift_next;
                    cnt       <= cnt - 1'b1;
                    if (cnt == SW'(1)) begin
                        result    <= shift_next;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    // A request arriving alongside res_ready waits for the next IDLE cycle.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        alu_sel   <= SEL_ADD;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
